// File: rtl/otter_muldiv_pkg.sv
// otter_muldiv_pkg: shared types and constants for the OTTER RV32M multiply/divide unit
package otter_muldiv_pkg;
  localparam int MD_WIDTH = 32;
  localparam int MD_LATENCY = MD_WIDTH + 2;
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_funct3_e;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX, ST_DONE} md_state_e;
  function automatic logic signed_a(input md_funct3_e f);
    return f inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction
  function automatic logic signed_b(input md_funct3_e f);
    return f inside {MD_MULH, MD_DIV, MD_REM};
  endfunction
endpackage

// File: rtl/otter_muldiv_if.sv
// otter_muldiv_if: start/operand/result bus between control unit and multiply/divide unit
interface otter_muldiv_if #(parameter int WIDTH = 32);
  logic             md_start;
  logic [2:0]       md_funct3;
  logic [WIDTH-1:0] md_a;
  logic [WIDTH-1:0] md_b;
  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  modport master (output md_start, md_funct3, md_a, md_b, input md_busy, md_done, md_result);
  modport slave (input md_start, md_funct3, md_a, md_b, output md_busy, md_done, md_result);
endinterface

// File: rtl/otter_muldiv_signfix.sv
// otter_muldiv_signfix: sign correction, special cases and result select for the raw magnitude results
module otter_muldiv_signfix import otter_muldiv_pkg::*; #(
  parameter int WIDTH = MD_WIDTH
) (
  input  md_funct3_e           i_fn,
  input  logic [2*WIDTH-1:0]   i_prod,
  input  logic [WIDTH-1:0]     i_quo,
  input  logic [WIDTH-1:0]     i_rem,
  input  logic [WIDTH-1:0]     i_a,
  input  logic                 i_sa,
  input  logic                 i_sb,
  input  logic                 i_div0,
  output logic [WIDTH-1:0]     o_result
);
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  always_comb begin
    w_prod = (i_sa ^ i_sb) ? -i_prod : i_prod;
    w_quo = i_div0 ? '1 : (i_sa ^ i_sb) ? -i_quo : i_quo;
    w_rem = i_div0 ? i_a : i_sa ? -i_rem : i_rem;
    o_result = i_fn == MD_MUL ? w_prod[WIDTH-1:0] :
               i_fn inside {MD_DIV, MD_DIVU} ? w_quo :
               i_fn inside {MD_REM, MD_REMU} ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  end
endmodule

// File: rtl/otter_muldiv.sv
// otter_muldiv: iterative RV32M multiply/divide unit with fixed WIDTH+2 cycle latency
module otter_muldiv import otter_muldiv_pkg::*; #(
  parameter int WIDTH = MD_WIDTH
) (
  input logic         clk,
  input logic         rst,
  otter_muldiv_if.slave io_md
);
  localparam int CW = $clog2(WIDTH);
  md_state_e          r_state, w_next;
  md_funct3_e         r_fn, w_fn;
  logic               r_sa, r_sb, r_done, w_sa, w_sb, w_ge;
  logic [WIDTH-1:0]   r_a, r_ma, r_mb, r_quo, r_rem, r_result, w_ma, w_mb, w_res;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH:0]     w_sum, w_shift;
  logic [CW-1:0]      r_cnt;
  assign w_fn = md_funct3_e'(io_md.md_funct3);
  assign w_sa = signed_a(w_fn) & io_md.md_a[WIDTH-1];
  assign w_sb = signed_b(w_fn) & io_md.md_b[WIDTH-1];
  assign w_ma = w_sa ? -io_md.md_a : io_md.md_a;
  assign w_mb = w_sb ? -io_md.md_b : io_md.md_b;
  assign w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_ma} : '0);
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge = w_shift >= {1'b0, r_mb};
  assign io_md.md_busy = r_state != ST_IDLE;
  assign io_md.md_done = r_done;
  assign io_md.md_result = r_result;
  otter_muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .i_fn(r_fn),
    .i_prod(r_prod),
    .i_quo(r_quo),
    .i_rem(r_rem),
    .i_a(r_a),
    .i_sa(r_sa),
    .i_sb(r_sb),
    .i_div0(r_mb == '0),
    .o_result(w_res)
  );
  always_comb begin
    w_next = r_state;
    w_next = r_state == ST_IDLE ? (io_md.md_start ? ST_CALC : ST_IDLE) :
             r_state == ST_CALC ? (r_cnt == CW'(WIDTH - 1) ? ST_FIX : ST_CALC) :
             r_state == ST_FIX  ? ST_DONE : ST_IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= ST_IDLE;
      r_fn <= MD_MUL;
      r_sa <= 1'b0;
      r_sb <= 1'b0;
      r_done <= 1'b0;
      r_a <= '0;
      r_ma <= '0;
      r_mb <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_result <= '0;
      r_prod <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_done <= r_state == ST_DONE;
      if (r_state == ST_IDLE && io_md.md_start) begin
        r_fn <= w_fn;
        r_sa <= w_sa;
        r_sb <= w_sb;
        r_a <= io_md.md_a;
        r_ma <= w_ma;
        r_mb <= w_mb;
        r_prod <= {{WIDTH{1'b0}}, w_mb};
        r_quo <= w_ma;
        r_rem <= '0;
        r_cnt <= '0;
      end
      if (r_state == ST_CALC) begin
        r_cnt <= r_cnt + CW'(1);
        r_prod <= {w_sum, r_prod[WIDTH-1:1]};
        r_rem <= w_ge ? WIDTH'(w_shift - {1'b0, r_mb}) : w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], w_ge};
      end
      if (r_state == ST_FIX) r_result <= w_res;
    end
endmodule

// File: tb/tb_otter_muldiv.sv
// tb_otter_muldiv: directed self-checking bench for otter_muldiv
module tb_otter_muldiv;
  import otter_muldiv_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_total = 0;
  otter_muldiv_if #(.WIDTH(32)) md();
  otter_muldiv #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .io_md(md));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic run_op(input string tag, input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int inj);
    int k;
    logic busy_ok;
    @(negedge clk);
    md.md_start = 1'b1;
    md.md_funct3 = fn;
    md.md_a = a;
    md.md_b = b;
    @(negedge clk);
    md.md_start = 1'b0;
    md.md_funct3 = 3'($urandom);
    md.md_a = $urandom;
    md.md_b = $urandom;
    busy_ok = md.md_busy;
    k = 0;
    while (k < 40 && !md.md_done) begin
      @(negedge clk);
      k++;
      md.md_start = (k == inj);
      if (!md.md_done) busy_ok &= md.md_busy;
    end
    md.md_start = 1'b0;
    check({tag, " latency"}, 32'(k), 32'd34);
    check({tag, " result"}, md.md_result, exp);
    check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    check({tag, " done_pulse"}, {31'd0, md.md_done}, 32'd0);
  endtask
  initial begin
    logic seen;
    md.md_start = 1'b1;
    md.md_funct3 = MD_MUL;
    md.md_a = 32'd3;
    md.md_b = 32'd4;
    repeat (3) @(negedge clk);
    check("rst busy", {31'd0, md.md_busy}, 32'd0);
    check("rst done", {31'd0, md.md_done}, 32'd0);
    check("rst result", md.md_result, 32'd0);
    rst = 1'b0;
    md.md_start = 1'b0;
    @(negedge clk);
    check("start in rst ignored", {31'd0, md.md_busy}, 32'd0);
    run_op("MUL", MD_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0);
    run_op("MULH", MD_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 0);
    run_op("MULHU", MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    run_op("MULHSU", MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op("DIV", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0);
    run_op("REM", MD_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0);
    run_op("DIVU ignore_start", MD_DIVU, 32'd100, 32'd7, 32'd14, 5);
    run_op("REMU", MD_REMU, 32'd100, 32'd7, 32'd2, 0);
    run_op("DIV0", MD_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 0);
    @(negedge clk);
    md.md_start = 1'b1;
    md.md_funct3 = MD_MUL;
    md.md_a = 32'd3;
    md.md_b = 32'd5;
    @(negedge clk);
    md.md_start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", {31'd0, md.md_busy}, 32'd0);
    check("abort done", {31'd0, md.md_done}, 32'd0);
    check("abort result", md.md_result, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= md.md_done;
    end
    check("abort no done", {31'd0, seen}, 32'd0);
    run_op("DIVU0", MD_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 0);
    run_op("REM0", MD_REM, 32'd5, 32'd0, 32'd5, 0);
    run_op("DIV ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    run_op("REM ovf", MD_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
